// File: rtl/key_debounce_pulse_pkg.sv
// key_debounce_pulse_pkg: shared FSM state encodings and key level constants.
// Imported by key_debounce_pulse and sync_ff users; no ports.
package key_debounce_pulse_pkg;
   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_HELD         = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } state_t;
   localparam logic KEY_RELEASED_LVL = 1'b1;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: STAGES-deep flop chain bringing an asynchronous bit into the clk_i domain.
// Ports: clk_i clock, clr_i async active-high clear (loads RST_VAL), d_i async input, q_o synchronised output.
module sync_ff #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic clr_i,
   input  logic d_i,
   output logic q_o
);
   logic [STAGES-1:0] sync_q;
   always_ff @(posedge clk_i or posedge clr_i)
      if (clr_i) sync_q <= {STAGES{RST_VAL}};
      else       sync_q <= {sync_q[STAGES-2:0], d_i};
   assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse: debounces an active-low pushbutton into a level plus one-cycle press/release pulses.
// Ports: Clk clock, Clr async active-high reset, Key_n raw button (0 = pressed),
//        Pressed debounced level, Press_pulse / Release_pulse one-cycle strobes per accepted edge.
module key_debounce_pulse
   import key_debounce_pulse_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic Clk,
   input  logic Clr,
   input  logic Key_n,
   output logic Pressed,
   output logic Press_pulse,
   output logic Release_pulse
);
   localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES);
   logic                 key_s;
   logic                 pressed_s;
   logic                 cnt_done;
   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 pressed_q, pressed_d;
   logic                 press_q, press_d;
   logic                 release_q, release_d;
   sync_ff #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (KEY_RELEASED_LVL)
   ) u_sync (
      .clk_i (Clk),
      .clr_i (Clr),
      .d_i   (Key_n),
      .q_o   (key_s)
   );
   assign pressed_s = ~key_s;
   assign cnt_done  = cnt_q == CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   // cnt_d defaults to 0 so every state entry and every stable state clears the counter
   always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
         ST_IDLE:       if (pressed_s) state_d = ST_PRESS_WAIT;
         ST_PRESS_WAIT:
            if (!pressed_s) state_d = ST_IDLE;
            else if (cnt_done) begin
               state_d = ST_HELD;
               press_d = 1'b1;
            end else cnt_d = cnt_q + 1'b1;
         ST_HELD:       if (!pressed_s) state_d = ST_RELEASE_WAIT;
         ST_RELEASE_WAIT:
            if (pressed_s) state_d = ST_HELD;
            else if (cnt_done) begin
               state_d   = ST_IDLE;
               release_d = 1'b1;
            end else cnt_d = cnt_q + 1'b1;
         default:       state_d = ST_IDLE;
      endcase
      pressed_d = (state_d == ST_HELD) || (state_d == ST_RELEASE_WAIT);
   end
   always_ff @(posedge Clk or posedge Clr)
      if (Clr) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         pressed_q <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pressed_q <= pressed_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   assign Pressed       = pressed_q;
   assign Press_pulse   = press_q;
   assign Release_pulse = release_q;
endmodule

// File: tb/tb_key_debounce_pulse.sv
// tb_key_debounce_pulse: randomized and directed checks of key_debounce_pulse against a run-length model.
module tb_key_debounce_pulse;
   localparam int S = 2;
   localparam int D = 4;
   logic clk = 1'b0;
   logic clr = 1'b1;
   logic key_n = 1'b1;
   logic pressed, press_pulse, release_pulse;
   int   tests = 0;
   int   fails = 0;
   int   pp_cnt = 0;
   int   rp_cnt = 0;
   bit   m_pressed = 1'b0;
   bit   m_pp = 1'b0;
   bit   m_rp = 1'b0;
   int   run = 0;
   bit   pipe[$];
   key_debounce_pulse #(
      .SYNC_STAGES     (S),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .Clk           (clk),
      .Clr           (clr),
      .Key_n         (key_n),
      .Pressed       (pressed),
      .Press_pulse   (press_pulse),
      .Release_pulse (release_pulse)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic got, input logic exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
      end
   endtask
   // The model sees the key S edges late, and flips its level once the opposite
   // value has been seen on D+1 consecutive edges.
   always @(posedge clk or posedge clr) begin
      if (clr) begin
         pipe.delete();
         for (int i = 0; i < S; i++) pipe.push_back(1'b1);
         m_pressed = 1'b0;
         m_pp = 1'b0;
         m_rp = 1'b0;
         run = 0;
      end else begin
         bit ps;
         ps = ~pipe.pop_front();
         pipe.push_back(key_n);
         m_pp = 1'b0;
         m_rp = 1'b0;
         if (ps != m_pressed) begin
            run++;
            if (run == D + 1) begin
               m_pressed = ps;
               run = 0;
               if (ps) m_pp = 1'b1;
               else    m_rp = 1'b1;
            end
         end else run = 0;
      end
   end
   always @(negedge clk) begin
      chk("model_pressed", pressed, m_pressed);
      chk("model_press_pulse", press_pulse, m_pp);
      chk("model_release_pulse", release_pulse, m_rp);
      chk("pulses_exclusive", press_pulse & release_pulse, 1'b0);
      pp_cnt += int'(press_pulse);
      rp_cnt += int'(release_pulse);
   end
   task automatic edges(input int n);
      repeat (n) @(negedge clk);
   endtask
   initial begin
      int pp0, rp0, seen;
      edges(2);
      chk("reset_pressed", pressed, 1'b0);
      chk("reset_pp", press_pulse, 1'b0);
      chk("reset_rp", release_pulse, 1'b0);
      clr = 1'b0;
      edges(3);
      // clean press: key goes low now, next posedge is edge 0
      key_n = 1'b0;
      edges(6);
      chk("press_e5_pp", press_pulse, 1'b0);
      chk("press_e5_lvl", pressed, 1'b0);
      edges(1);
      chk("press_e6_pp", press_pulse, 1'b1);
      chk("press_e6_lvl", pressed, 1'b1);
      edges(1);
      chk("press_e7_pp", press_pulse, 1'b0);
      chk("press_e7_lvl", pressed, 1'b1);
      // short release bounce of 4 samples keeps the level
      rp0 = rp_cnt;
      key_n = 1'b1;
      edges(4);
      key_n = 1'b0;
      edges(10);
      chk("rel_bounce_lvl", pressed, 1'b1);
      chk("rel_bounce_rp", rp_cnt != rp0, 1'b0);
      // clean release
      key_n = 1'b1;
      edges(6);
      chk("rel_e5_rp", release_pulse, 1'b0);
      chk("rel_e5_lvl", pressed, 1'b1);
      edges(1);
      chk("rel_e6_rp", release_pulse, 1'b1);
      chk("rel_e6_lvl", pressed, 1'b0);
      edges(1);
      chk("rel_e7_rp", release_pulse, 1'b0);
      // press bounce: 3 low, 3 high, five times
      pp0 = pp_cnt;
      seen = 0;
      for (int r = 0; r < 5; r++) begin
         key_n = 1'b0;
         for (int i = 0; i < 3; i++) begin edges(1); seen += int'(pressed); end
         key_n = 1'b1;
         for (int i = 0; i < 3; i++) begin edges(1); seen += int'(pressed); end
      end
      edges(8);
      chk("bounce_no_level", seen != 0, 1'b0);
      chk("bounce_no_pulse", pp_cnt != pp0, 1'b0);
      // long hold: exactly one press pulse, no release until let go
      pp0 = pp_cnt;
      rp0 = rp_cnt;
      key_n = 1'b0;
      edges(1000);
      chk("hold_one_pp", pp_cnt - pp0 == 1, 1'b1);
      chk("hold_no_rp", rp_cnt != rp0, 1'b0);
      key_n = 1'b1;
      edges(10);
      chk("hold_then_rp", rp_cnt - rp0 == 1, 1'b1);
      // reset in PRESS_WAIT with cnt=2 (after edge 4)
      key_n = 1'b0;
      edges(5);
      #2 clr = 1'b1;
      #1;
      chk("clr_pw_lvl", pressed, 1'b0);
      chk("clr_pw_pp", press_pulse, 1'b0);
      chk("clr_pw_rp", release_pulse, 1'b0);
      edges(2);
      clr = 1'b0;
      edges(6);
      chk("clr_pw_e5_pp", press_pulse, 1'b0);
      edges(1);
      chk("clr_pw_e6_pp", press_pulse, 1'b1);
      chk("clr_pw_e6_lvl", pressed, 1'b1);
      // reset while held, then release: no release pulse
      edges(3);
      rp0 = rp_cnt;
      #2 clr = 1'b1;
      #1;
      chk("clr_held_lvl", pressed, 1'b0);
      edges(1);
      clr = 1'b0;
      key_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin edges(1); seen += int'(pressed); end
      chk("clr_held_no_rp", rp_cnt != rp0, 1'b0);
      chk("clr_held_stay_low", seen != 0, 1'b0);
      // randomized runs with occasional async reset, checked by the model
      for (int r = 0; r < 600; r++) begin
         key_n = 1'($urandom_range(0, 1));
         edges($urandom_range(1, 9));
         if ($urandom_range(0, 29) == 0) begin
            #2 clr = 1'b1;
            #1;
            chk("rand_clr_lvl", pressed, 1'b0);
            #1 clr = 1'b0;
         end
      end
      edges(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
